dcm_ps_ctrl: RTL and testbench

- Initiator for the DCM variable phase-shift port. Drives PSEN/PSINCDEC and consumes PSDONE, stepping the DCM one tap per handshake until a requested signed tap offset is reached.
- Sits beside the DCM in the clocking region and runs on the same PSCLK that feeds the DCM.
- Exposes a simple REQ/ACK target interface plus position and status to fabric logic.

---
 rtl/dcm_ps_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_dcm_ps_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_ps_ctrl.sv
// DCM variable phase-shift initiator: steps PSEN/PSINCDEC one tap per PSDONE until POSITION
// reaches a clamped signed target. Optional PSDONE watchdog under `DCM_PS_TIMEOUT_EN.
module dcm_ps_ctrl #(
  parameter int unsigned PS_WIDTH       = 9,
  parameter int unsigned PS_MAX         = 255,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                       psclk,
  input  logic                       rst_n,
  input  logic                       req,
  input  logic signed [PS_WIDTH-1:0] target,
  output logic                       req_ack,
  input  logic                       locked,
  input  logic                       psdone,
  output logic                       psen,
  output logic                       psincdec,
  output logic signed [PS_WIDTH-1:0] position,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitLock,
    StIssue,
    StWaitDone,
    StSettle,
    StFinish
  } state_e;

  localparam logic signed [PS_WIDTH-1:0] PsMaxP = PS_WIDTH'(PS_MAX);
  localparam logic signed [PS_WIDTH-1:0] PsMinP = -PsMaxP;

  state_e                     state_q, state_d;
  logic signed [PS_WIDTH-1:0] tgt_q, tgt_d;
  logic signed [PS_WIDTH-1:0] pos_q, pos_d;
  logic [3:0]                 settle_cnt_q, settle_cnt_d;
  logic                       psen_q, psen_d;
  logic                       psincdec_q, psincdec_d;
  logic                       req_ack_q, req_ack_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic signed [PS_WIDTH-1:0] tgt_clamped;
  logic                       clamp_hit;
  logic                       settle_last;

`ifdef DCM_PS_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            tmo_expire;
  // Fires so that DONE lands exactly TIMEOUT_CYCLES after the PSEN pulse.
  assign tmo_expire = (32'(tmo_cnt_q) + 32'd2) >= TIMEOUT_CYCLES;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    tgt_clamped = target;
    clamp_hit   = 1'b0;
    if (target > PsMaxP) begin
      tgt_clamped = PsMaxP;
      clamp_hit   = 1'b1;
    end else if (target < PsMinP) begin
      tgt_clamped = PsMinP;
      clamp_hit   = 1'b1;
    end
  end

  // SETTLE always lasts at least one cycle, even with SETTLE_CYCLES = 0.
  assign settle_last = ({1'b0, settle_cnt_q} + 5'd1) >= 5'(SETTLE_CYCLES);

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    pos_d        = pos_q;
    settle_cnt_d = settle_cnt_q;
    psincdec_d   = psincdec_q;
    err_d        = err_q;
    psen_d       = 1'b0;
    req_ack_d    = 1'b0;
    done_d       = 1'b0;
`ifdef DCM_PS_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!locked) pos_d = '0;
        if (req) begin
          req_ack_d = 1'b1;
          tgt_d     = tgt_clamped;
          err_d     = clamp_hit;
          state_d   = StWaitLock;
        end
      end
      StWaitLock: begin
        if (locked) state_d = (tgt_q == pos_q) ? StFinish : StIssue;
      end
      StIssue: begin
        if (!locked) begin
          err_d   = 1'b1;
          pos_d   = '0;
          state_d = StFinish;
        end else begin
          psen_d     = 1'b1;
          psincdec_d = tgt_q > pos_q;
          state_d    = StWaitDone;
`ifdef DCM_PS_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end
      end
      StWaitDone: begin
        if (!locked) begin
          err_d   = 1'b1;
          pos_d   = '0;
          state_d = StFinish;
        end else if (psdone) begin
          pos_d        = psincdec_q ? pos_q + 1'b1 : pos_q - 1'b1;
          settle_cnt_d = '0;
          state_d      = StSettle;
        end
`ifdef DCM_PS_TIMEOUT_EN
        else if (tmo_expire) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
`endif
      end
      StSettle: begin
        if (!locked) begin
          err_d   = 1'b1;
          pos_d   = '0;
          state_d = StFinish;
        end else if (settle_last) begin
          state_d = (pos_q == tgt_q) ? StFinish : StIssue;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge psclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tgt_q        <= '0;
      pos_q        <= '0;
      settle_cnt_q <= '0;
      psen_q       <= 1'b0;
      psincdec_q   <= 1'b0;
      req_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      pos_q        <= pos_d;
      settle_cnt_q <= settle_cnt_d;
      psen_q       <= psen_d;
      psincdec_q   <= psincdec_d;
      req_ack_q    <= req_ack_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

`ifdef DCM_PS_TIMEOUT_EN
  always_ff @(posedge psclk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  assign psen     = psen_q;
  assign psincdec = psincdec_q;
  assign req_ack  = req_ack_q;
  assign position = pos_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dcm_ps_ctrl.sv
// Directed bench for dcm_ps_ctrl with a behavioural DCM returning PSDONE 4 cycles after PSEN.
module tb_dcm_ps_ctrl;

  localparam int unsigned W = 10;
  localparam int K = 4;

  logic                psclk = 1'b0;
  logic                rst_n;
  logic                req;
  logic signed [W-1:0] target;
  logic                req_ack;
  logic                locked;
  logic                psdone = 1'b0;
  logic                psen;
  logic                psincdec;
  logic signed [W-1:0] position;
  logic                busy;
  logic                done;
  logic                err;

  dcm_ps_ctrl #(
    .PS_WIDTH      (W),
    .PS_MAX        (255),
    .SETTLE_CYCLES (2),
    .TIMEOUT_CYCLES(1023)
  ) u_dut (
    .psclk   (psclk),
    .rst_n   (rst_n),
    .req     (req),
    .target  (target),
    .req_ack (req_ack),
    .locked  (locked),
    .psdone  (psdone),
    .psen    (psen),
    .psincdec(psincdec),
    .position(position),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 psclk = ~psclk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int psen_tot = 0, inc_tot = 0, dec_tot = 0, done_tot = 0, overlap = 0;
  int rsp_cnt = 0;
  bit outstanding = 1'b0;
  bit dcm_en = 1'b1;

  // DCM model and event counters, sampled 1 time unit after each rising edge.
  always @(posedge psclk) begin
    cyc++;
    #1;
    psdone = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        psdone      = 1'b1;
        outstanding = 1'b0;
      end
    end
    if (done) begin
      done_tot++;
      outstanding = 1'b0;
    end
    if (psen) begin
      psen_tot++;
      if (psincdec) inc_tot++;
      else          dec_tot++;
      if (outstanding) overlap++;
      outstanding = 1'b1;
      if (dcm_en) rsp_cnt = K;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_req(input int v, output int t);
    t = -1;
    @(negedge psclk);
    req    = 1'b1;
    target = W'(v);
    for (int i = 0; i < 200; i++) begin
      @(posedge psclk);
      #1;
      if (req_ack) begin
        t = cyc;
        break;
      end
    end
    req = 1'b0;
    if (t < 0) chk("req_ack_timeout", 0, 1);
  endtask

  task automatic wait_psen(output int p);
    p = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge psclk);
      #1;
      if (psen) begin
        p = cyc;
        break;
      end
    end
    if (p < 0) chk("psen_timeout", 0, 1);
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int i = 0; i < 5000; i++) begin
      @(posedge psclk);
      #1;
      if (done) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge psclk);
    #1;
  endtask

  initial begin
    int t, p, d, b_psen, b_inc, b_dec, b_done;
    rst_n  = 1'b0;
    req    = 1'b0;
    target = '0;
    locked = 1'b1;
    #12;
    chk("rst_outputs", {psen, psincdec, req_ack, busy, done, err}, 0);
    chk("rst_position", position, 0);
    @(negedge psclk);
    rst_n = 1'b1;
    idle_cycles(2);

    // +3 from 0: three increments, one step every 8 cycles.
    b_psen = psen_tot; b_inc = inc_tot; b_done = done_tot;
    do_req(3, t);
    chk("up3_err_at_ack", err, 0);
    wait_psen(p);
    chk("up3_first_psen_lat", p - t, 2);
    wait_done(d);
    chk("up3_done_lat", d - t, 26);
    chk("up3_busy_at_done", busy, 0);
    chk("up3_position", position, 3);
    chk("up3_err", err, 0);
    idle_cycles(3);
    chk("up3_psen_count", psen_tot - b_psen, 3);
    chk("up3_inc_count", inc_tot - b_inc, 3);
    chk("up3_done_count", done_tot - b_done, 1);

    // 3 -> -2: five decrements.
    b_psen = psen_tot; b_dec = dec_tot;
    do_req(-2, t);
    wait_done(d);
    chk("dn_done_lat", d - t, 42);
    chk("dn_position", position, -2);
    chk("dn_err", err, 0);
    chk("dn_dec_count", dec_tot - b_dec, 5);
    chk("dn_psen_count", psen_tot - b_psen, 5);

    // +300 clamps to 255: ERR at accept, 257 increments.
    b_inc = inc_tot;
    do_req(300, t);
    chk("clamp_err_at_ack", err, 1);
    wait_done(d);
    chk("clamp_done_lat", d - t, 2 + 8 * 257);
    chk("clamp_position", position, 255);
    chk("clamp_err", err, 1);
    chk("clamp_inc_count", inc_tot - b_inc, 257);

    // Target equals position: no PSEN, DONE 2 cycles after REQ_ACK, ERR cleared.
    b_psen = psen_tot;
    do_req(255, t);
    chk("same_err_cleared", err, 0);
    wait_done(d);
    chk("same_done_lat", d - t, 2);
    chk("same_psen_count", psen_tot - b_psen, 0);

    // Move to 5, then lose lock with PSDONE withheld.
    do_req(5, t);
    wait_done(d);
    chk("to5_position", position, 5);
    dcm_en = 1'b0;
    b_psen = psen_tot; b_done = done_tot;
    do_req(9, t);
    wait_psen(p);
    idle_cycles(50);
    chk("hang_busy", busy, 1);
    chk("hang_position", position, 5);
    chk("hang_no_done", done_tot - b_done, 0);
    @(negedge psclk);
    locked = 1'b0;
    wait_done(d);
    chk("lock_err", err, 1);
    chk("lock_position", position, 0);
    idle_cycles(10);
    chk("lock_psen_count", psen_tot - b_psen, 1);
    chk("lock_done_count", done_tot - b_done, 1);
    @(negedge psclk);
    locked = 1'b1;
    dcm_en = 1'b1;
    do_req(1, t);
    chk("relock_err_cleared", err, 0);
    wait_done(d);
    chk("relock_done_lat", d - t, 10);
    chk("relock_position", position, 1);
    chk("relock_err", err, 0);

`ifdef DCM_PS_TIMEOUT_EN
    // PSDONE withheld: watchdog ends the move with POSITION unchanged.
    dcm_en = 1'b0;
    do_req(3, t);
    wait_psen(p);
    wait_done(d);
    chk("tmo_done_lat", d - p, 1023);
    chk("tmo_err", err, 1);
    chk("tmo_position", position, 1);
    dcm_en = 1'b1;
    idle_cycles(2);
`endif

    chk("no_early_psen", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
